// File: rtl/my_chip.sv
// Three-road traffic-light controller with turn arrow and pedestrian phase, round-robin arbitration.
// Define PED_FLASH_EN to make the orange clearance light flash during CLEAR.
module my_chip #(
  parameter int GREEN_CYCLES  = 5,
  parameter int YELLOW_CYCLES = 2,
  parameter int WALK_CYCLES   = 5,
  parameter int CLEAR_CYCLES  = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] io_in,
  output logic [11:0] io_out
);
  localparam int MAX_A = (GREEN_CYCLES > YELLOW_CYCLES) ? GREEN_CYCLES : YELLOW_CYCLES;
  localparam int MAX_B = (WALK_CYCLES > CLEAR_CYCLES) ? WALK_CYCLES : CLEAR_CYCLES;
  localparam int MAXC  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int TW    = $clog2(MAXC) + 1;

  localparam logic [1:0] PH_A = 2'd0, PH_B = 2'd1, PH_C = 2'd2, PH_P = 2'd3;

  typedef enum logic [3:0] {ALL_RED, G1, Y1, G2, Y2, G3, Y3, WALK, CLEAR} state_t;

  typedef struct packed {
    logic red1, yellow1, green1;
    logic red2, yellow2, green2;
    logic red3, yellow3, green3;
    logic turn, orange, white;
  } lights_t;

  localparam lights_t LIGHTS_RST = lights_t'(12'b100_100_100_010);

  state_t        state, yel;
  lights_t       lights;
  logic [TW-1:0] timer, lim_m1;
  logic [1:0]    last, sel, idx, cur_ph;
  logic [3:0]    car_q, pend;
  logic          ped_req, sel_vld, t_last, hold;
  logic          unused_hi;

  assign unused_hi = ^io_in[11:5];
  assign io_out    = lights;

  function automatic lights_t show(state_t s, logic g3, logic trn);
    lights_t l;
    l = LIGHTS_RST;
    case (s)
      G1:      begin l.red1 = 1'b0; l.green1  = 1'b1; end
      Y1:      begin l.red1 = 1'b0; l.yellow1 = 1'b1; end
      G2:      begin l.red2 = 1'b0; l.green2  = 1'b1; end
      Y2:      begin l.red2 = 1'b0; l.yellow2 = 1'b1; end
      G3:      begin l.red3 = !g3;  l.green3  = g3; l.turn = trn; end
      Y3:      begin l.red3 = 1'b0; l.yellow3 = 1'b1; end
      WALK:    begin l.orange = 1'b0; l.white = 1'b1; end
      default: ;
    endcase
    return l;
  endfunction

  // car_q[0]=car1 .. car_q[3]=car4; pending bit per phase A,B,C,P
  assign pend = {ped_req, car_q[2] | car_q[3], car_q[1], car_q[0]};

  always_comb begin
    sel     = PH_A;
    sel_vld = 1'b0;
    idx     = '0;
    // Scan downward so the nearest pending phase after last wins; k=4 wraps back to last itself.
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (pend[idx]) begin
        sel     = idx;
        sel_vld = 1'b1;
      end
    end

    cur_ph = PH_A;
    yel    = Y1;
    lim_m1 = TW'(YELLOW_CYCLES - 1);
    case (state)
      G1, Y1:      cur_ph = PH_A;
      G2, Y2:      begin cur_ph = PH_B; yel = Y2; end
      G3, Y3:      begin cur_ph = PH_C; yel = Y3; end
      WALK, CLEAR: cur_ph = PH_P;
      default: ;
    endcase
    case (state)
      G1, G2, G3: lim_m1 = TW'(GREEN_CYCLES - 1);
      WALK:       lim_m1 = TW'(WALK_CYCLES - 1);
      CLEAR:      lim_m1 = TW'(CLEAR_CYCLES - 1);
      default: ;
    endcase
    t_last = (timer == lim_m1);
    hold   = pend[cur_ph] && ((pend & ~(4'b0001 << cur_ph)) == 4'b0000);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= ALL_RED;
      lights  <= LIGHTS_RST;
      timer   <= '0;
      last    <= PH_P;
      ped_req <= 1'b0;
      car_q   <= '0;
    end else begin
      car_q <= {io_in[1], io_in[2], io_in[3], io_in[4]};
      if (io_in[0] && state != WALK && state != CLEAR) ped_req <= 1'b1;
      case (state)
        ALL_RED: if (sel_vld) begin
          last  <= sel;
          timer <= '0;
          case (sel)
            PH_A: begin state <= G1; lights <= show(G1, 1'b0, 1'b0); end
            PH_B: begin state <= G2; lights <= show(G2, 1'b0, 1'b0); end
            PH_C: begin state <= G3; lights <= show(G3, car_q[2], car_q[3]); end
            default: begin
              state   <= WALK;
              lights  <= show(WALK, 1'b0, 1'b0);
              ped_req <= 1'b0;
            end
          endcase
        end
        // Timer saturates at the minimum green, then the phase holds while uncontested.
        G1, G2, G3: begin
          if (!t_last) timer <= timer + TW'(1);
          else if (!hold) begin
            state  <= yel;
            timer  <= '0;
            lights <= show(yel, 1'b0, 1'b0);
          end
        end
        WALK: begin
          if (t_last) begin
            state  <= CLEAR;
            timer  <= '0;
            lights <= show(CLEAR, 1'b0, 1'b0);
          end else timer <= timer + TW'(1);
        end
        default: begin
          if (t_last) begin
            state  <= ALL_RED;
            timer  <= '0;
            lights <= LIGHTS_RST;
          end else begin
            timer <= timer + TW'(1);
`ifdef PED_FLASH_EN
            if (state == CLEAR) lights.orange <= ~lights.orange;
`endif
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_my_chip.sv
// Directed-vector bench for my_chip plus a random-input safety invariant sweep.
module tb_my_chip;
  logic        clock, reset;
  logic [11:0] io_in, io_out;
  logic        car1, car2, car3, car4, button;
  logic [6:0]  hi;
  int          checks, errors;

  localparam logic [11:0] ALLR  = 12'b100_100_100_010;
  localparam logic [11:0] WALKO = 12'b100_100_100_001;
  localparam logic [11:0] G1O   = 12'b001_100_100_010;
  localparam logic [11:0] Y1O   = 12'b010_100_100_010;
  localparam logic [11:0] G2O   = 12'b100_001_100_010;
  localparam logic [11:0] Y2O   = 12'b100_010_100_010;
  localparam logic [11:0] G3T   = 12'b100_100_001_110;
  localparam logic [11:0] TURNO = 12'b100_100_100_110;
  localparam logic [11:0] Y3O   = 12'b100_100_010_010;
  localparam logic [11:0] CLR_A = ALLR;
`ifdef PED_FLASH_EN
  localparam logic [11:0] CLR_B = 12'b100_100_100_000;
`else
  localparam logic [11:0] CLR_B = ALLR;
`endif

  assign io_in = {hi, car1, car2, car3, car4, button};

  my_chip dut (.clock(clock), .reset(reset), .io_in(io_in), .io_out(io_out));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b exp %b", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic expect_n(input string tag, input logic [11:0] exp, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk(tag, io_out, exp);
    end
  endtask

  task automatic invariant;
    int act;
    logic ok;
    act = int'(!io_out[11]) + int'(!io_out[8]) + int'(!io_out[5] || io_out[2]) + int'(io_out[0]);
    ok = $onehot(io_out[11:9]) && $onehot(io_out[8:6]) && $onehot(io_out[5:3]) &&
         (act <= 1) && !(io_out[1] && io_out[0]);
`ifndef PED_FLASH_EN
    ok = ok && (io_out[1] || io_out[0]);
`endif
    chk("invariant", {11'b0, ok}, 12'd1);
  endtask

  initial begin
    checks = 0; errors = 0;
    {car1, car2, car3, car4, button} = '0;
    hi = '0;
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (4) @(negedge clock);
    chk("rst_hold", io_out, ALLR);
    reset = 1'b1;
    expect_n("idle", ALLR, 3);

    // pedestrian only, second press during WALK must be ignored
    button = 1'b1; tick(); chk("ped_latch", io_out, ALLR);
    button = 1'b0;
    expect_n("ped_walk", WALKO, 2);
    button = 1'b1; expect_n("ped_walk", WALKO, 1);
    button = 1'b0; expect_n("ped_walk", WALKO, 2);
    expect_n("ped_clr1", CLR_A, 1);
    expect_n("ped_clr2", CLR_B, 1);
    expect_n("ped_done", ALLR, 3);

    // button then car1: ped runs first, car1 gone by the end
    button = 1'b1; tick(); chk("bc_pend", io_out, ALLR);
    car1 = 1'b1;
    expect_n("bc_walk", WALKO, 3);
    button = 1'b0; expect_n("bc_walk", WALKO, 1);
    car1 = 1'b0; expect_n("bc_walk", WALKO, 1);
    expect_n("bc_clr1", CLR_A, 1);
    expect_n("bc_clr2", CLR_B, 1);
    expect_n("bc_idle", ALLR, 3);

    // car1 held beyond minimum, then car2 contends, then round robin back to car1
    car1 = 1'b1; tick(); chk("g1_req", io_out, ALLR);
    expect_n("g1_hold", G1O, 8);
    car2 = 1'b1; expect_n("g1_tail", G1O, 1);
    expect_n("y1", Y1O, 2);
    expect_n("ar1", ALLR, 1);
    expect_n("g2", G2O, 5);
    expect_n("y2", Y2O, 2);
    expect_n("ar2", ALLR, 1);
    expect_n("g1_rr", G1O, 1);
    car1 = 1'b0; car2 = 1'b0;
    expect_n("g1_min", G1O, 4);
    expect_n("y1b", Y1O, 2);
    expect_n("ar3", ALLR, 2);

    // car3 and car4 together
    car3 = 1'b1; car4 = 1'b1; tick(); chk("c_req", io_out, ALLR);
    expect_n("g3t", G3T, 1);
    car3 = 1'b0; car4 = 1'b0;
    expect_n("g3t", G3T, 4);
    expect_n("y3", Y3O, 2);
    expect_n("ar4", ALLR, 2);

    // turn lane only: road 3 stays red while the arrow is lit
    car4 = 1'b1; tick(); chk("t_req", io_out, ALLR);
    expect_n("turn", TURNO, 1);
    car4 = 1'b0;
    expect_n("turn", TURNO, 4);
    expect_n("y3t", Y3O, 2);
    expect_n("ar5", ALLR, 1);

    // asynchronous reset mid-green, then car1 wins over car2 after reset
    car1 = 1'b1; tick(); expect_n("pre_rst", G1O, 2);
    #2 reset = 1'b0;
    #1 chk("async_rst", io_out, ALLR);
    car1 = 1'b0;
    @(negedge clock); reset = 1'b1;
    expect_n("post_rst", ALLR, 2);
    car1 = 1'b1; car2 = 1'b1; tick(); chk("rr_req", io_out, ALLR);
    expect_n("rr_reset", G1O, 1);
    car1 = 1'b0; car2 = 1'b0;
    expect_n("rr_g1", G1O, 4);
    expect_n("rr_y1", Y1O, 2);
    expect_n("rr_ar", ALLR, 1);

    // random stimulus safety sweep
    for (int i = 0; i < 10000; i++) begin
      {hi, car1, car2, car3, car4, button} = 12'($urandom);
      tick();
      invariant();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
